// File: rtl/dma_pkg.sv
// Shared constants for the DMA datapath: word width, control register bit
// positions and the default geometry of the stream FIFO.
package dma_pkg;

  localparam int unsigned DMA_DATA_W = 32;

  typedef enum logic [1:0] {
    CTRL_ACTIVE  = 2'd0,
    CTRL_MODE    = 2'd1,
    CTRL_INC_DST = 2'd3
  } ctrl_bit_e;

  localparam int unsigned FIFO_DEPTH    = 16;
  localparam int unsigned FIFO_ADDR_W   = 4;
  localparam int unsigned FIFO_AF_LEVEL = 12;

endpackage

// File: rtl/dma_fifo_mem.sv
// FIFO storage: DEPTH x DATA_W register array, one synchronous write port and
// one asynchronous read port. Contents are intentionally not reset.
module dma_fifo_mem #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dma_stream_fifo.sv
// First-word-fall-through FIFO between the stream processor and the DMA write
// engine, with level/almost-full reporting, sticky error flags and flush.
module dma_stream_fifo
  import dma_pkg::*;
#(
  parameter int unsigned DATA_W   = DMA_DATA_W,
  parameter int unsigned DEPTH    = FIFO_DEPTH,
  parameter int unsigned ADDR_W   = FIFO_ADDR_W,
  parameter int unsigned AF_LEVEL = FIFO_AF_LEVEL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr_enable,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              almost_full,
  input  logic              rd_enable,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam logic [ADDR_W:0]   LVL_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LVL_AF    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0]   LVL_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   level_q, level_d;
  logic              overflow_q, underflow_q;
  logic              push_ok, pop_ok, push_rej, pop_rej;
  logic [DATA_W-1:0] head;

  // Flags come from the registered level only, so accept decisions never
  // depend on same-cycle requests (no bypass when empty, no pass-through when full).
  assign empty       = (level_q == '0);
  assign full        = (level_q == LVL_DEPTH);
  assign almost_full = (level_q >= LVL_AF);
  assign level       = level_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign rd_data     = empty ? '0 : head;

  always_comb begin
    push_ok  = wr_enable & ~full  & ~flush;
    pop_ok   = rd_enable & ~empty & ~flush;
    push_rej = wr_enable &  full  & ~flush;
    pop_rej  = rd_enable &  empty & ~flush;
    level_d  = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      level_q <= level_d;
    end
  end

  // A rejected request in the same cycle as err_clr still leaves the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_rej)     overflow_q <= 1'b1;
      else if (err_clr) overflow_q <= 1'b0;
      if (pop_rej)       underflow_q <= 1'b1;
      else if (err_clr)  underflow_q <= 1'b0;
    end
  end

  dma_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

endmodule

// File: tb/tb_dma_stream_fifo.sv
// Scoreboard bench for dma_stream_fifo: pushed words are queued, popped words
// are compared at the head, and all flags are checked after each clock edge.
module tb_dma_stream_fifo;

  logic        clk = 1'b0;
  logic        reset, flush, wr_enable, rd_enable, err_clr;
  logic [31:0] wr_data;
  logic        full, almost_full, empty, overflow, underflow;
  logic [31:0] rd_data;
  logic [4:0]  level;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  logic [31:0] sb_q[$];
  bit          m_ovf, m_udf;

  always #5 clk = ~clk;

  dma_stream_fifo #(
    .DATA_W   (32),
    .DEPTH    (16),
    .ADDR_W   (4),
    .AF_LEVEL (12)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .wr_enable   (wr_enable),
    .wr_data     (wr_data),
    .full        (full),
    .almost_full (almost_full),
    .rd_enable   (rd_enable),
    .rd_data     (rd_data),
    .empty       (empty),
    .level       (level),
    .overflow    (overflow),
    .underflow   (underflow),
    .err_clr     (err_clr)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    int unsigned sz;
    sz = sb_q.size();
    check_val({tag, ".level"}, 32'(level), sz);
    check_val({tag, ".empty"}, 32'(empty), 32'(sz == 0));
    check_val({tag, ".full"}, 32'(full), 32'(sz == 16));
    check_val({tag, ".afull"}, 32'(almost_full), 32'(sz >= 12));
    check_val({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    check_val({tag, ".udf"}, 32'(underflow), 32'(m_udf));
    check_val({tag, ".rdata"}, rd_data, (sz == 0) ? 32'h0 : sb_q[0]);
  endtask

  // Inputs are driven 1 time unit after a rising edge; outputs checked the same way.
  task automatic step(input string tag, input bit wr, input logic [31:0] wd,
                      input bit rd, input bit fl, input bit ec);
    bit m_empty, m_full;
    m_empty = (sb_q.size() == 0);
    m_full  = (sb_q.size() == 16);
    wr_enable = wr; wr_data = wd; rd_enable = rd; flush = fl; err_clr = ec;
    if (fl) begin
      sb_q.delete();
      if (ec) begin m_ovf = 0; m_udf = 0; end
    end else begin
      if (rd && !m_empty) begin
        check_val({tag, ".pop"}, rd_data, sb_q[0]);
        void'(sb_q.pop_front());
      end
      if (wr && !m_full) sb_q.push_back(wd);
      if (wr && m_full) m_ovf = 1;
      else if (ec)      m_ovf = 0;
      if (rd && m_empty) m_udf = 1;
      else if (ec)       m_udf = 0;
    end
    @(posedge clk); #1;
    wr_enable = 0; rd_enable = 0; flush = 0; err_clr = 0;
    check_outputs(tag);
  endtask

  task automatic drain(input string tag);
    for (int unsigned i = 0; i < 20 && sb_q.size() > 0; i++) step(tag, 0, 0, 1, 0, 0);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, ".level"}, 32'(level), 0);
    check_val({tag, ".empty"}, 32'(empty), 1);
    check_val({tag, ".full"}, 32'(full), 0);
    check_val({tag, ".afull"}, 32'(almost_full), 0);
    check_val({tag, ".ovf"}, 32'(overflow), 0);
    check_val({tag, ".udf"}, 32'(underflow), 0);
    check_val({tag, ".rdata"}, rd_data, 0);
  endtask

  initial begin
    logic [31:0] nxt;
    reset = 0; flush = 0; wr_enable = 0; rd_enable = 0; err_clr = 0; wr_data = '0;
    m_ovf = 0; m_udf = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst");
    reset = 1;
    @(posedge clk); #1;

    // single word through
    step("t1.push", 1, 32'hA5A5_0001, 0, 0, 0);
    step("t1.pop", 0, 0, 1, 0, 0);

    // fill, overflow, drain in order
    for (int unsigned i = 0; i < 16; i++) step("t2.fill", 1, i, 0, 0, 0);
    step("t2.ovf", 1, 32'hDEAD_BEEF, 0, 0, 0);
    drain("t2.drain");
    step("t2.clr", 0, 0, 0, 0, 1);

    // full with simultaneous push+pop
    for (int unsigned i = 0; i < 16; i++) step("t3.fill", 1, 32'h100 + i, 0, 0, 0);
    step("t3.pp", 1, 32'h0BAD_0BAD, 1, 0, 0);
    drain("t3.drain");
    step("t3.clr", 0, 0, 0, 0, 1);

    // empty with simultaneous push+pop
    step("t4.pp", 1, 32'h77, 1, 0, 0);
    step("t4.ovf", 1, 32'h78, 0, 0, 0);
    for (int unsigned i = 0; i < 15; i++) step("t4.fill", 1, 32'h200 + i, 0, 0, 0);
    step("t4.ovfset", 1, 32'h299, 0, 0, 0);
    step("t4.clr", 0, 0, 0, 0, 1);
    drain("t4.drain");

    // steady level 3 across pointer wrap
    nxt = 32'h3000;
    for (int unsigned i = 0; i < 3; i++) begin step("t5.pre", 1, nxt, 0, 0, 0); nxt++; end
    for (int unsigned i = 0; i < 40; i++) begin
      step("t5.stream", 1, nxt, 1, 0, 0);
      nxt++;
    end
    drain("t5.drain");

    // flush beats push/pop
    for (int unsigned i = 0; i < 9; i++) step("t6.fill", 1, 32'h600 + i, 0, 0, 0);
    step("t6.flush", 1, 32'h6FF, 1, 1, 0);
    step("t6.after", 1, 32'h6AA, 0, 0, 0);

    // async reset mid-burst
    for (int unsigned i = 0; i < 5; i++) step("t6.burst", 1, 32'h700 + i, 0, 0, 0);
    wr_enable = 1; wr_data = 32'h7FF;
    #3;
    reset = 0;
    #1;
    sb_q.delete(); m_ovf = 0; m_udf = 0;
    check_reset_state("t6.arst");
    wr_enable = 0;
    @(posedge clk); #1;
    check_reset_state("t6.arst_hold");
    reset = 1;
    step("t6.post", 1, 32'h800, 0, 0, 0);
    step("t6.postpop", 0, 0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
